// File: rtl/board_io_pkg.sv
// ----------------------------------------------------------------------------
// board_io_pkg
// Shared constants and helpers for the board I/O conditioning stage.
//   CLK_HZ                   board clock frequency
//   DEFAULT_DEBOUNCE_CYCLES  10 ms worth of CLK_HZ cycles
//   debounce_cnt_width()     width of a counter that can hold 0..cycles
// ----------------------------------------------------------------------------
package board_io_pkg;

    localparam int unsigned CLK_HZ                  = 27_000_000;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;

    function automatic int unsigned debounce_cnt_width(int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/board_io_conditioner_if.sv
// ----------------------------------------------------------------------------
// board_io_conditioner_if
// Groups the pin-side and logic-side signals of board_io_conditioner.
//   buttons_raw/switches_raw  raw pins into the conditioner
//   buttons/_press/_release   debounced button level and 1-cycle edge pulses
//   switches                  debounced switch level
//   leds/led_brightness       logical LED request and PWM duty
//   leds_pin                  physical LED pins
// Modports: master drives inputs and observes outputs, slave is the conditioner.
// ----------------------------------------------------------------------------
interface board_io_conditioner_if #(
    parameter int unsigned BUTTONS  = 5,
    parameter int unsigned SWITCHES = 4,
    parameter int unsigned LEDS     = 6,
    parameter int unsigned PWM_BITS = 8
) ();

    logic [BUTTONS-1:0]  buttons_raw;
    logic [SWITCHES-1:0] switches_raw;
    logic [BUTTONS-1:0]  buttons;
    logic [BUTTONS-1:0]  buttons_press;
    logic [BUTTONS-1:0]  buttons_release;
    logic [SWITCHES-1:0] switches;
    logic [LEDS-1:0]     leds;
    logic [PWM_BITS-1:0] led_brightness;
    logic [LEDS-1:0]     leds_pin;

    modport master (
        output buttons_raw, switches_raw, leds, led_brightness,
        input  buttons, buttons_press, buttons_release, switches, leds_pin
    );

    modport slave (
        input  buttons_raw, switches_raw, leds, led_brightness,
        output buttons, buttons_press, buttons_release, switches, leds_pin
    );

endinterface

// File: rtl/io_debouncer.sv
// ----------------------------------------------------------------------------
// io_debouncer
// One input channel: synchroniser chain, stability counter, accepted level and
// one-cycle edge pulses registered in the same cycle the level changes.
//   clk_i    clock
//   rst_i    synchronous active-high reset
//   in_i     logical (polarity-corrected) asynchronous input
//   level_o  debounced level
//   rise_o   1-cycle pulse on accepted 0->1
//   fall_o   1-cycle pulse on accepted 1->0
// ----------------------------------------------------------------------------
module io_debouncer
    import board_io_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Count only while the synchronised input disagrees with the accepted
    // level; any agreement restarts the window, so bounces never accumulate.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (synced == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            stable_d = synced;
            cnt_d    = '0;
            rise_d   = synced;
            fall_d   = ~synced;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], in_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/board_io_conditioner.sv
// ----------------------------------------------------------------------------
// board_io_conditioner
// Conditioning stage between raw board pins and the core logic: normalises
// pin polarity, synchronises and debounces buttons/switches, produces
// press/release pulses and registers the LED pins.
//   clk_27M  sole clock
//   rst      synchronous active-high reset
//   io       board_io_conditioner_if.slave (raw pins, conditioned levels,
//            pulses, LED request/brightness, LED pins)
// Build option: define LED_PWM_EN for PWM LED brightness; without it the
// brightness input is ignored and LEDs follow the request directly.
// ----------------------------------------------------------------------------
module board_io_conditioner
    import board_io_pkg::*;
#(
    parameter int unsigned BUTTONS           = 5,
    parameter int unsigned SWITCHES          = 4,
    parameter int unsigned LEDS              = 6,
    parameter bit          BUTTON_ACTIVE_LOW = 1'b1,
    parameter bit          LED_ACTIVE_LOW    = 1'b1,
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned PWM_BITS          = 8
) (
    input  logic                  clk_27M,
    input  logic                  rst,
    board_io_conditioner_if.slave io
);

    localparam logic [LEDS-1:0] LedOff = {LEDS{LED_ACTIVE_LOW}};

    // ---------------- Buttons ----------------
    for (genvar i = 0; i < BUTTONS; i++) begin : g_btn
        io_debouncer #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i   (clk_27M),
            .rst_i   (rst),
            .in_i    (io.buttons_raw[i] ^ BUTTON_ACTIVE_LOW),
            .level_o (io.buttons[i]),
            .rise_o  (io.buttons_press[i]),
            .fall_o  (io.buttons_release[i])
        );
    end

    // ---------------- Switches (level only) ----------------
    for (genvar i = 0; i < SWITCHES; i++) begin : g_sw
        io_debouncer #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i   (clk_27M),
            .rst_i   (rst),
            .in_i    (io.switches_raw[i] ^ BUTTON_ACTIVE_LOW),
            .level_o (io.switches[i]),
            .rise_o  (),
            .fall_o  ()
        );
    end

    // ---------------- LEDs ----------------
    logic [LEDS-1:0] pin_q, pin_d;

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] bright_q;
    logic [PWM_BITS-1:0] bright_eff;
    logic                lit_en;

    // The new duty is used from the counter-0 cycle on, so a period never
    // mixes two brightness values.
    assign bright_eff = (pwm_cnt_q == '0) ? io.led_brightness : bright_q;
    assign lit_en     = (bright_eff == '1) || (pwm_cnt_q < bright_eff);

    always_comb begin
        pin_d = (io.leds & {LEDS{lit_en}}) ^ LedOff;
    end

    always_ff @(posedge clk_27M) begin
        if (rst) begin
            pwm_cnt_q <= '0;
            bright_q  <= '0;
            pin_q     <= LedOff;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            if (pwm_cnt_q == '0) begin
                bright_q <= io.led_brightness;
            end
            pin_q <= pin_d;
        end
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^io.led_brightness;

    always_comb begin
        pin_d = io.leds ^ LedOff;
    end

    always_ff @(posedge clk_27M) begin
        if (rst) begin
            pin_q <= LedOff;
        end else begin
            pin_q <= pin_d;
        end
    end
`endif

    assign io.leds_pin = pin_q;

endmodule

// File: tb/tb_board_io_conditioner.sv
module tb_board_io_conditioner;

    localparam int unsigned BUTTONS  = 5;
    localparam int unsigned SWITCHES = 4;
    localparam int unsigned LEDS     = 6;
    localparam int unsigned PWM_BITS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    board_io_conditioner_if #(
        .BUTTONS  (BUTTONS),
        .SWITCHES (SWITCHES),
        .LEDS     (LEDS),
        .PWM_BITS (PWM_BITS)
    ) bus ();

    board_io_conditioner #(
        .BUTTONS         (BUTTONS),
        .SWITCHES        (SWITCHES),
        .LEDS            (LEDS),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .PWM_BITS        (PWM_BITS)
    ) dut (
        .clk_27M (clk),
        .rst     (rst),
        .io      (bus)
    );

    // Advance one rising edge, return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.buttons_raw    = 5'b11111;
        bus.switches_raw   = 4'b1111;
        bus.leds           = '0;
        bus.led_brightness = '0;
        repeat (3) tick();
        tests++;
        if (bus.buttons !== 5'b0) begin
            fails++; $display("FAIL reset_buttons got %b want %b", bus.buttons, 5'b0);
        end
        tests++;
        if (bus.buttons_press !== 5'b0 || bus.buttons_release !== 5'b0) begin
            fails++; $display("FAIL reset_pulses got %b/%b want 0/0",
                              bus.buttons_press, bus.buttons_release);
        end
        tests++;
        if (bus.switches !== 4'b0) begin
            fails++; $display("FAIL reset_switches got %b want %b", bus.switches, 4'b0);
        end
        tests++;
        if (bus.leds_pin !== 6'b111111) begin
            fails++; $display("FAIL reset_leds_pin got %b want %b", bus.leds_pin, 6'b111111);
        end
        rst = 1'b0;
        repeat (8) tick();
        tests++;
        if (bus.buttons !== 5'b0 || bus.buttons_press !== 5'b0) begin
            fails++; $display("FAIL idle_after_reset got %b/%b want 0/0",
                              bus.buttons, bus.buttons_press);
        end
    endtask

    task automatic test_clean_press();
        logic exp_lvl;
        logic exp_pulse;
        bus.buttons_raw[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_lvl   = (k >= 6);
            exp_pulse = (k == 6);
            tests++;
            if (bus.buttons[0] !== exp_lvl) begin
                fails++; $display("FAIL clean_level edge %0d got %b want %b",
                                  k, bus.buttons[0], exp_lvl);
            end
            tests++;
            if (bus.buttons_press[0] !== exp_pulse) begin
                fails++; $display("FAIL clean_press edge %0d got %b want %b",
                                  k, bus.buttons_press[0], exp_pulse);
            end
        end
    endtask

    task automatic test_bounce();
        int       npress = 0;
        logic     exp_pulse;
        for (int seg = 0; seg < 10; seg++) begin
            bus.buttons_raw[2] = (seg % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) begin
                tick();
                if (bus.buttons_press[2] === 1'b1) npress++;
                tests++;
                if (bus.buttons[2] !== 1'b0) begin
                    fails++; $display("FAIL bounce_level seg %0d got %b want 0",
                                      seg, bus.buttons[2]);
                end
            end
        end
        bus.buttons_raw[2] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (bus.buttons_press[2] === 1'b1) npress++;
            exp_pulse = (k == 6);
            tests++;
            if (bus.buttons_press[2] !== exp_pulse) begin
                fails++; $display("FAIL bounce_press edge %0d got %b want %b",
                                  k, bus.buttons_press[2], exp_pulse);
            end
        end
        tests++;
        if (npress != 1) begin
            fails++; $display("FAIL bounce_count got %0d want 1", npress);
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] exp_p;
        logic [4:0] exp_r;
        bus.buttons_raw[3] = 1'b0;
        repeat (8) tick();
        tests++;
        if (bus.buttons !== 5'b01101) begin
            fails++; $display("FAIL simul_setup got %b want %b", bus.buttons, 5'b01101);
        end
        bus.buttons_raw[1] = 1'b0;
        bus.buttons_raw[3] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_p = (k == 6) ? 5'b00010 : 5'b00000;
            exp_r = (k == 6) ? 5'b01000 : 5'b00000;
            tests++;
            if (bus.buttons_press !== exp_p || bus.buttons_release !== exp_r) begin
                fails++; $display("FAIL simul_pulses edge %0d got %b/%b want %b/%b",
                                  k, bus.buttons_press, bus.buttons_release, exp_p, exp_r);
            end
        end
        tests++;
        if (bus.buttons !== 5'b00111) begin
            fails++; $display("FAIL simul_level got %b want %b", bus.buttons, 5'b00111);
        end
    endtask

    task automatic test_switches();
        logic [3:0] exp_sw;
        bus.switches_raw = 4'b1010;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_sw = (k >= 6) ? 4'b0101 : 4'b0000;
            tests++;
            if (bus.switches !== exp_sw) begin
                fails++; $display("FAIL switch_on edge %0d got %b want %b",
                                  k, bus.switches, exp_sw);
            end
        end
        bus.switches_raw = 4'b1111;
        repeat (6) tick();
        tests++;
        if (bus.switches !== 4'b0000) begin
            fails++; $display("FAIL switch_off got %b want %b", bus.switches, 4'b0000);
        end
    endtask

`ifndef LED_PWM_EN
    task automatic test_leds();
        bus.leds = 6'b000001;
        #1;
        tests++;
        if (bus.leds_pin !== 6'b111111) begin
            fails++; $display("FAIL led_before_edge got %b want %b", bus.leds_pin, 6'b111111);
        end
        tick();
        tests++;
        if (bus.leds_pin !== 6'b111110) begin
            fails++; $display("FAIL led_one got %b want %b", bus.leds_pin, 6'b111110);
        end
        bus.leds = 6'b101010;
        tick();
        tests++;
        if (bus.leds_pin !== 6'b010101) begin
            fails++; $display("FAIL led_alt got %b want %b", bus.leds_pin, 6'b010101);
        end
        bus.leds = 6'b000000;
        tick();
        tests++;
        if (bus.leds_pin !== 6'b111111) begin
            fails++; $display("FAIL led_off got %b want %b", bus.leds_pin, 6'b111111);
        end
    endtask
`else
    task automatic test_pwm();
        int lows = 0;
        bus.leds           = 6'b000001;
        bus.led_brightness = 8'd64;
        repeat (300) tick();
        repeat (256) begin
            tick();
            if (bus.leds_pin[0] === 1'b0) lows++;
        end
        tests++;
        if (lows != 64) begin
            fails++; $display("FAIL pwm_duty got %0d want 64", lows);
        end
        tests++;
        if (bus.leds_pin[5:1] !== 5'b11111) begin
            fails++; $display("FAIL pwm_others got %b want %b", bus.leds_pin[5:1], 5'b11111);
        end
        bus.leds           = 6'b000000;
        bus.led_brightness = 8'd0;
        repeat (2) tick();
    endtask
`endif

    task automatic test_reset_mid_debounce();
        logic [4:0] exp_p;
        bus.buttons_raw[4] = 1'b0;
        repeat (4) begin
            tick();
            tests++;
            if (bus.buttons_press[4] !== 1'b0) begin
                fails++; $display("FAIL midrst_pre got %b want 0", bus.buttons_press[4]);
            end
        end
        rst = 1'b1;
        tick();
        tests++;
        if (bus.buttons !== 5'b0 || bus.buttons_press !== 5'b0) begin
            fails++; $display("FAIL midrst_in_reset got %b/%b want 0/0",
                              bus.buttons, bus.buttons_press);
        end
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_p = (k == 6) ? 5'b10111 : 5'b00000;
            tests++;
            if (bus.buttons_press !== exp_p) begin
                fails++; $display("FAIL midrst_press edge %0d got %b want %b",
                                  k, bus.buttons_press, exp_p);
            end
        end
        tests++;
        if (bus.buttons !== 5'b10111) begin
            fails++; $display("FAIL midrst_level got %b want %b", bus.buttons, 5'b10111);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_switches();
`ifndef LED_PWM_EN
        test_leds();
`else
        test_pwm();
`endif
        test_reset_mid_debounce();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
